tap_ctrl: RTL and testbench
===========================

// Module: tap_ctrl
// PURPOSE
//  IEEE 1149.1-style TAP controller; the stage directly upstream of the boundary-scan
//  cell chain. Decodes TMS into the 16-state TAP FSM and holds the instruction register.
//  Drives the chain's serial input, shift/capture/update strobes and EXTEST mode select,
//  and muxes chain/bypass/IDCODE/IR data onto TDO.
// PARAMETERS
//  IR_W      4             instruction register width, >=2
//  IDCODE    32'h1000_0001 device ID, bit0 must be 1; used only with TAP_IDCODE_EN
// PORTS
//  clock        in   1     TCK; the only clock, all state updates on rising edge
//  reset_l      in   1     async active-low reset (TRST*)
//  tms          in   1     test mode select, sampled on rising edge
//  tdi          in   1     test data in
//  tdo          out  1     test data out, registered
//  tdo_en       out  1     high while tdo carries valid shift data, registered
//  chain_si     out  1     serial in to boundary chain; equals tdi (combinational)
//  chain_so     in   1     serial out of last boundary cell
//  chain_shift  out  1     combinational; high in SHIFT_DR with EXTEST/SAMPLE selected
//  chain_capture out 1     combinational; high in CAPTURE_DR with EXTEST/SAMPLE selected
//  chain_update out  1     combinational; high in UPDATE_DR with EXTEST/SAMPLE selected
//  chain_mode   out  1     registered; 1 when IR==EXTEST (drives cell SE: hold/drive pins)
//  tap_state    out  4     current FSM state encoding (debug)
//  ir           out  IR_W  current instruction
// BEHAVIOUR
//  Reset (async, reset_l=0): state=TEST_LOGIC_RESET, ir=reset instr (see CONFIG),
//   ir_shift=0, bypass=0, tdo=0, tdo_en=0, chain_mode=0. Reset mid-shift aborts; no update.
//  Encoding: TLR=F RTI=C SELDR=7 CAPDR=6 SHDR=2 EX1DR=1 PADR=3 EX2DR=0 UPDR=5
//   SELIR=4 CAPIR=E SHIR=A EX1IR=9 PAIR=B EX2IR=8 UPIR=D.
//  Transitions (tms=0 / tms=1): TLR->RTI/TLR; RTI->RTI/SELDR; SELDR->CAPDR/SELIR;
//   SELIR->CAPIR/TLR; CAPxR->SHxR/EX1xR; SHxR->SHxR/EX1xR; EX1xR->PAxR/UPxR;
//   PAxR->PAxR/EX2xR; EX2xR->SHxR/UPxR; UPxR->RTI/SELDR.
//  Five consecutive tms=1 edges reach TLR from any state; in TLR, ir <= reset instr.
//  Instructions: EXTEST=0..0, SAMPLE=0..01, IDCODE=0..010, BYPASS=1..1;
//   any other code decodes as BYPASS.
//  IR path: in CAPIR, ir_shift <= {0..0,2'b01}; in SHIR, ir_shift <= {tdi, ir_shift[IR_W-1:1]};
//   in UPIR, ir <= ir_shift (one edge after entering UPIR). ir unchanged in PAIR/EX*IR.
//  DR select: EXTEST/SAMPLE -> boundary chain; IDCODE -> 32-bit id reg; else 1-bit bypass.
//   Bypass: CAPDR loads 0; SHDR loads tdi. IDCODE reg: CAPDR loads IDCODE; SHDR shifts right, tdi in MSB.
//  TDO: on every edge with state SHIR/SHDR, tdo <= LSB of selected register
//   (chain_so for boundary) before that edge's shift; tdo_en <= 1 then, else tdo_en <= 0
//   and tdo holds. One-cycle latency: first bit visible the cycle after first SHxR edge.
//  chain_mode updates only on the UPIR edge (new ir == EXTEST); holds through DR scans.
//  Chain strobes are decoded from current state and ir, so no strobes fire during IR scans.
// CONFIGURATION
//  TAP_IDCODE_EN defined: 32-bit IDCODE register present; reset instr = IDCODE.
//  TAP_IDCODE_EN undefined: no IDCODE register; code 0..010 decodes as BYPASS;
//   reset instr = BYPASS (1..1). IDCODE parameter unused.
// TESTING
//  Reset: reset_l=0 mid-SHDR -> tap_state=F, tdo=0, tdo_en=0, chain_mode=0, ir=reset instr.
//  From RTI, tms=1,1,1,1,1 -> tap_state=F after 5th edge; any 4 -> not yet F unless start near TLR.
//  IR scan IR_W=4: shift tdi=0,0,0,0 -> tdo stream 1,0,0,0; UPIR -> ir=0000, chain_mode=1.
//  Bypass: ir=1111, shift tdi=1,0,1,1 in SHDR -> tdo=0,1,0,1 (1-cycle delay, leading capture 0).
//  EXTEST DR scan, 8-cell chain loop: chain_capture 1 cycle in CAPDR, chain_shift high 8
//   cycles, chain_update 1 cycle in UPDR; tdo mirrors chain_so delayed one edge.
//  TAP_IDCODE_EN: after reset, CAPDR + 32 SHDR edges -> tdo emits 32'h1000_0001 LSB first;
//   without macro, same sequence -> single 0 then tdi delayed (bypass).

Source files
------------

// File: rtl/tap_if.sv
// TAP-side bundle: debugger pins (tms/tdi/tdo) plus boundary-chain control and debug taps.
// The controller uses the slave view; the debugger/chain environment uses the master view.
interface tap_if #(
  parameter int IR_W = 4
);
  logic            tms;
  logic            tdi;
  logic            tdo;
  logic            tdo_en;
  logic            chain_si;
  logic            chain_so;
  logic            chain_shift;
  logic            chain_capture;
  logic            chain_update;
  logic            chain_mode;
  logic [3:0]      tap_state;
  logic [IR_W-1:0] ir;

  modport slave (
    input  tms, tdi, chain_so,
    output tdo, tdo_en, chain_si, chain_shift, chain_capture, chain_update,
           chain_mode, tap_state, ir
  );

  modport master (
    output tms, tdi, chain_so,
    input  tdo, tdo_en, chain_si, chain_shift, chain_capture, chain_update,
           chain_mode, tap_state, ir
  );
endinterface

// File: rtl/tap_ctrl.sv
// IEEE 1149.1-style TAP controller feeding a boundary-scan chain.
// Define TAP_IDCODE_EN to add the 32-bit IDCODE data register (and make IDCODE the reset instruction).
module tap_ctrl #(
  parameter int          IR_W   = 4,
  parameter logic [31:0] IDCODE = 32'h1000_0001
) (
  input logic  clock,
  input logic  reset_l,
  tap_if.slave bus
);

  typedef enum logic [3:0] {
    ST_TLR   = 4'hF, ST_RTI   = 4'hC, ST_SELDR = 4'h7, ST_CAPDR = 4'h6,
    ST_SHDR  = 4'h2, ST_EX1DR = 4'h1, ST_PADR  = 4'h3, ST_EX2DR = 4'h0,
    ST_UPDR  = 4'h5, ST_SELIR = 4'h4, ST_CAPIR = 4'hE, ST_SHIR  = 4'hA,
    ST_EX1IR = 4'h9, ST_PAIR  = 4'hB, ST_EX2IR = 4'h8, ST_UPIR  = 4'hD
  } tap_state_e;

  localparam logic [IR_W-1:0] INSTR_EXTEST = {IR_W{1'b0}};
  localparam logic [IR_W-1:0] INSTR_SAMPLE = IR_W'(1'b1);
  localparam logic [IR_W-1:0] IR_CAPTURE   = IR_W'(2'b01);
`ifdef TAP_IDCODE_EN
  localparam logic [IR_W-1:0] INSTR_IDCODE = IR_W'(2'b10);
  localparam logic [IR_W-1:0] RESET_INSTR  = INSTR_IDCODE;
`else
  localparam logic [IR_W-1:0] INSTR_BYPASS = {IR_W{1'b1}};
  localparam logic [IR_W-1:0] RESET_INSTR  = INSTR_BYPASS;
`endif

  if (IR_W < 2) begin : g_bad_ir_w
    $error("tap_ctrl: IR_W must be at least 2");
  end
  if (IDCODE[0] != 1'b1) begin : g_bad_idcode
    $error("tap_ctrl: IDCODE bit 0 must be 1");
  end

  tap_state_e      state_q, state_d;
  logic [IR_W-1:0] ir_q, ir_d;
  logic [IR_W-1:0] ir_shift_q, ir_shift_d;
  logic            bypass_q, bypass_d;
  logic            tdo_q, tdo_d;
  logic            tdo_en_q, tdo_en_d;
  logic            chain_mode_q, chain_mode_d;
`ifdef TAP_IDCODE_EN
  logic [31:0]     idcode_q, idcode_d;
`endif
  logic            sel_boundary_s;
  logic            dr_lsb_s;
  logic            chain_shift_s, chain_capture_s, chain_update_s;

  // FSM state register; TRST* forces Test-Logic-Reset immediately
  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= ST_TLR;
    end else begin
      state_q <= state_d;
    end
  end

  // TMS-driven next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_TLR:   state_d = bus.tms ? ST_TLR   : ST_RTI;
      ST_RTI:   state_d = bus.tms ? ST_SELDR : ST_RTI;
      ST_SELDR: state_d = bus.tms ? ST_SELIR : ST_CAPDR;
      ST_CAPDR: state_d = bus.tms ? ST_EX1DR : ST_SHDR;
      ST_SHDR:  state_d = bus.tms ? ST_EX1DR : ST_SHDR;
      ST_EX1DR: state_d = bus.tms ? ST_UPDR  : ST_PADR;
      ST_PADR:  state_d = bus.tms ? ST_EX2DR : ST_PADR;
      ST_EX2DR: state_d = bus.tms ? ST_UPDR  : ST_SHDR;
      ST_UPDR:  state_d = bus.tms ? ST_SELDR : ST_RTI;
      ST_SELIR: state_d = bus.tms ? ST_TLR   : ST_CAPIR;
      ST_CAPIR: state_d = bus.tms ? ST_EX1IR : ST_SHIR;
      ST_SHIR:  state_d = bus.tms ? ST_EX1IR : ST_SHIR;
      ST_EX1IR: state_d = bus.tms ? ST_UPIR  : ST_PAIR;
      ST_PAIR:  state_d = bus.tms ? ST_EX2IR : ST_PAIR;
      ST_EX2IR: state_d = bus.tms ? ST_UPIR  : ST_SHIR;
      ST_UPIR:  state_d = bus.tms ? ST_SELDR : ST_RTI;
      default:  state_d = ST_TLR;
    endcase
  end

  assign sel_boundary_s = (ir_q == INSTR_EXTEST) || (ir_q == INSTR_SAMPLE);

  // Chain strobes follow the DR states only, so IR scans never disturb the cells
  always_comb begin
    chain_shift_s   = 1'b0;
    chain_capture_s = 1'b0;
    chain_update_s  = 1'b0;
    if (sel_boundary_s) begin
      case (state_q)
        ST_SHDR:  chain_shift_s   = 1'b1;
        ST_CAPDR: chain_capture_s = 1'b1;
        ST_UPDR:  chain_update_s  = 1'b1;
        default:  chain_shift_s   = 1'b0;
      endcase
    end else begin
      chain_shift_s = 1'b0;
    end
  end

  always_comb begin
    dr_lsb_s = bypass_q;
    if (sel_boundary_s) begin
      dr_lsb_s = bus.chain_so;
`ifdef TAP_IDCODE_EN
    end else if (ir_q == INSTR_IDCODE) begin
      dr_lsb_s = idcode_q[0];
`endif
    end else begin
      dr_lsb_s = bypass_q;
    end
  end

  // Register datapath: tdo samples the LSB before this edge's shift
  always_comb begin
    ir_d         = ir_q;
    ir_shift_d   = ir_shift_q;
    bypass_d     = bypass_q;
    tdo_d        = tdo_q;
    tdo_en_d     = 1'b0;
    chain_mode_d = chain_mode_q;
`ifdef TAP_IDCODE_EN
    idcode_d     = idcode_q;
`endif
    case (state_q)
      ST_TLR:   ir_d = RESET_INSTR;
      ST_CAPIR: ir_shift_d = IR_CAPTURE;
      ST_SHIR: begin
        ir_shift_d = {bus.tdi, ir_shift_q[IR_W-1:1]};
        tdo_d      = ir_shift_q[0];
        tdo_en_d   = 1'b1;
      end
      ST_UPIR: begin
        ir_d         = ir_shift_q;
        chain_mode_d = (ir_shift_q == INSTR_EXTEST);
      end
      ST_CAPDR: begin
        bypass_d = 1'b0;
`ifdef TAP_IDCODE_EN
        idcode_d = IDCODE;
`endif
      end
      ST_SHDR: begin
        bypass_d = bus.tdi;
        tdo_d    = dr_lsb_s;
        tdo_en_d = 1'b1;
`ifdef TAP_IDCODE_EN
        idcode_d = {bus.tdi, idcode_q[31:1]};
`endif
      end
      default: tdo_en_d = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      ir_q         <= RESET_INSTR;
      ir_shift_q   <= {IR_W{1'b0}};
      bypass_q     <= 1'b0;
      tdo_q        <= 1'b0;
      tdo_en_q     <= 1'b0;
      chain_mode_q <= 1'b0;
`ifdef TAP_IDCODE_EN
      idcode_q     <= 32'h0000_0000;
`endif
    end else begin
      ir_q         <= ir_d;
      ir_shift_q   <= ir_shift_d;
      bypass_q     <= bypass_d;
      tdo_q        <= tdo_d;
      tdo_en_q     <= tdo_en_d;
      chain_mode_q <= chain_mode_d;
`ifdef TAP_IDCODE_EN
      idcode_q     <= idcode_d;
`endif
    end
  end

  assign bus.tdo           = tdo_q;
  assign bus.tdo_en        = tdo_en_q;
  assign bus.chain_si      = bus.tdi;
  assign bus.chain_shift   = chain_shift_s;
  assign bus.chain_capture = chain_capture_s;
  assign bus.chain_update  = chain_update_s;
  assign bus.chain_mode    = chain_mode_q;
  assign bus.tap_state     = state_q;
  assign bus.ir            = ir_q;

endmodule

// File: tb/tb_tap_ctrl.sv
// Self-checking bench for tap_ctrl: directed scenarios plus a randomized TMS/TDI walk
// checked against a table-driven reference model and an 8-cell boundary chain model.
module tb_tap_ctrl;
  localparam int          IR_W = 4;
  localparam logic [31:0] IDC  = 32'h1000_0001;
`ifdef TAP_IDCODE_EN
  localparam logic [3:0]  RST_INSTR = 4'b0010;
`else
  localparam logic [3:0]  RST_INSTR = 4'b1111;
`endif

  logic clock = 1'b0;
  logic reset_l;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  tap_if #(.IR_W(IR_W)) bus ();
  tap_ctrl #(.IR_W(IR_W), .IDCODE(IDC)) dut (.clock(clock), .reset_l(reset_l), .bus(bus));

  // 8-cell boundary chain environment
  logic [7:0] chain_r = 8'h00;
  logic [7:0] pins_r  = 8'h00;
  always @(posedge clock) begin
    if (bus.chain_shift) chain_r <= {bus.chain_si, chain_r[7:1]};
    else if (bus.chain_capture) chain_r <= pins_r;
  end
  assign bus.chain_so = chain_r[0];

  // reference model: transition tables indexed by state code, plus register contents
  logic [3:0]  nx0 [0:15];
  logic [3:0]  nx1 [0:15];
  logic [3:0]  m_state;
  logic [3:0]  m_ir, m_irsh;
  logic        m_byp, m_tdo, m_en, m_mode;
  logic [31:0] m_id;

  function automatic logic m_boundary();
    return (m_ir == 4'h0) || (m_ir == 4'h1);
  endfunction

  function automatic logic m_selid();
`ifdef TAP_IDCODE_EN
    return (m_ir == 4'h2);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_state = 4'hF; m_ir = RST_INSTR; m_irsh = 4'h0; m_byp = 1'b0;
    m_tdo = 1'b0; m_en = 1'b0; m_mode = 1'b0; m_id = 32'h0;
  endtask

  task automatic model_edge(input logic t, input logic d, input logic so);
    logic [3:0] s;
    s = m_state;
    if (s == 4'hA) begin m_tdo = m_irsh[0]; m_en = 1'b1; end
    else if (s == 4'h2) begin
      m_en = 1'b1;
      if (m_boundary()) m_tdo = so;
      else if (m_selid()) m_tdo = m_id[0];
      else m_tdo = m_byp;
    end
    else m_en = 1'b0;
    if (s == 4'hF) m_ir = RST_INSTR;
    if (s == 4'hE) m_irsh = 4'h1;
    if (s == 4'hA) m_irsh = (m_irsh >> 1) | ({3'b000, d} << 3);
    if (s == 4'hD) begin m_ir = m_irsh; m_mode = (m_irsh == 4'h0); end
    if (s == 4'h6) begin m_byp = 1'b0; m_id = IDC; end
    if (s == 4'h2) begin m_byp = d; m_id = (m_id >> 1) | ({31'd0, d} << 31); end
    m_state = t ? nx1[s] : nx0[s];
  endtask

  task automatic step(input logic t, input logic d);
    bus.tms = t;
    bus.tdi = d;
    model_edge(t, d, bus.chain_so);
    @(posedge clock);
    #1;
  endtask

  task automatic go_rti();
    repeat (5) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic load_ir(input logic [3:0] code);
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < IR_W; i++) step(i == IR_W - 1, code[i]);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic reset_pulse();
    reset_l = 1'b0;
    #1;
    model_reset();
    @(negedge clock);
    reset_l = 1'b1;
  endtask

  task automatic test_reset();
    reset_l = 1'b0; bus.tms = 1'b1; bus.tdi = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    n_cmp++; if (bus.tap_state !== 4'hF) begin n_err++; $display("FAIL por_state got %h exp F", bus.tap_state); end
    n_cmp++; if (bus.ir !== RST_INSTR) begin n_err++; $display("FAIL por_ir got %b exp %b", bus.ir, RST_INSTR); end
    reset_l = 1'b1;
    step(1'b0, 1'b0);
    load_ir(4'h0);
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b1); step(1'b0, 1'b1);
    n_cmp++; if (bus.chain_mode !== 1'b1) begin n_err++; $display("FAIL pre_rst_mode got %b exp 1", bus.chain_mode); end
    #2 reset_l = 1'b0;
    #1;
    n_cmp++; if (bus.tap_state !== 4'hF) begin n_err++; $display("FAIL rst_state got %h exp F", bus.tap_state); end
    n_cmp++; if (bus.tdo !== 1'b0) begin n_err++; $display("FAIL rst_tdo got %b exp 0", bus.tdo); end
    n_cmp++; if (bus.tdo_en !== 1'b0) begin n_err++; $display("FAIL rst_tdo_en got %b exp 0", bus.tdo_en); end
    n_cmp++; if (bus.chain_mode !== 1'b0) begin n_err++; $display("FAIL rst_mode got %b exp 0", bus.chain_mode); end
    n_cmp++; if (bus.ir !== RST_INSTR) begin n_err++; $display("FAIL rst_ir got %b exp %b", bus.ir, RST_INSTR); end
    model_reset();
    @(negedge clock);
    reset_l = 1'b1;
  endtask

  task automatic test_tlr();
    go_rti();
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    repeat (4) step(1'b1, 1'b0);
    n_cmp++; if (bus.tap_state !== 4'h4) begin n_err++; $display("FAIL tlr_after4 got %h exp 4", bus.tap_state); end
    step(1'b1, 1'b0);
    n_cmp++; if (bus.tap_state !== 4'hF) begin n_err++; $display("FAIL tlr_after5 got %h exp F", bus.tap_state); end
    for (int k = 0; k < 8; k++) begin
      int n;
      n = $urandom_range(1, 20);
      for (int j = 0; j < n; j++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat (5) step(1'b1, 1'b0);
      n_cmp++; if (bus.tap_state !== 4'hF) begin n_err++; $display("FAIL tlr_rand%0d got %h exp F", k, bus.tap_state); end
    end
  endtask

  task automatic test_ir_scan();
    go_rti();
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(i == 3, 1'b0);
      n_cmp++;
      if (bus.tdo !== (i == 0) || bus.tdo_en !== 1'b1)
        begin n_err++; $display("FAIL ir_tdo%0d got %b/%b exp %b/1", i, bus.tdo, bus.tdo_en, (i == 0)); end
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    n_cmp++; if (bus.ir !== 4'h0) begin n_err++; $display("FAIL ir_update got %b exp 0000", bus.ir); end
    n_cmp++; if (bus.chain_mode !== 1'b1) begin n_err++; $display("FAIL ir_mode got %b exp 1", bus.chain_mode); end
  endtask

  task automatic test_bypass();
    logic [3:0] codes[$];
    logic [3:0] dat;
    codes.push_back(4'hF);
    codes.push_back(4'($urandom_range(3, 14)));
`ifndef TAP_IDCODE_EN
    codes.push_back(4'h2);
`endif
    foreach (codes[c]) begin
      go_rti();
      load_ir(codes[c]);
      n_cmp++; if (bus.ir !== codes[c]) begin n_err++; $display("FAIL byp_ir got %b exp %b", bus.ir, codes[c]); end
      dat = (c == 0) ? 4'b1101 : 4'($urandom_range(0, 15));
      step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
        logic e;
        e = (i == 0) ? 1'b0 : dat[i-1];
        step(i == 3, dat[i]);
        n_cmp++;
        if (bus.tdo !== e || bus.tdo_en !== 1'b1)
          begin n_err++; $display("FAIL byp_tdo ir=%b bit%0d got %b/%b exp %b/1", codes[c], i, bus.tdo, bus.tdo_en, e); end
      end
      step(1'b1, 1'b0); step(1'b0, 1'b0);
      n_cmp++; if (bus.chain_mode !== 1'b0) begin n_err++; $display("FAIL byp_mode got %b exp 0", bus.chain_mode); end
    end
  endtask

  task automatic test_extest();
    logic [7:0] din;
    int cap, sh, up;
    go_rti();
    load_ir(4'h0);
    pins_r = 8'($urandom_range(0, 255));
    din = 8'($urandom_range(0, 255));
    cap = 0; sh = 0; up = 0;
    for (int k = 0; k < 13; k++) begin
      logic t, d;
      t = (k == 0) || (k == 10) || (k == 11);
      d = (k >= 3 && k <= 10) ? din[k-3] : 1'b0;
      step(t, d);
      cap += int'(bus.chain_capture); sh += int'(bus.chain_shift); up += int'(bus.chain_update);
      if (k >= 3 && k <= 10) begin
        n_cmp++;
        if (bus.tdo !== pins_r[k-3] || bus.tdo_en !== 1'b1)
          begin n_err++; $display("FAIL ext_tdo bit%0d got %b/%b exp %b/1", k - 3, bus.tdo, bus.tdo_en, pins_r[k-3]); end
      end
    end
    n_cmp++; if (cap != 1) begin n_err++; $display("FAIL ext_capture_cycles got %0d exp 1", cap); end
    n_cmp++; if (sh != 8) begin n_err++; $display("FAIL ext_shift_cycles got %0d exp 8", sh); end
    n_cmp++; if (up != 1) begin n_err++; $display("FAIL ext_update_cycles got %0d exp 1", up); end
    n_cmp++; if (chain_r !== din) begin n_err++; $display("FAIL ext_chain got %h exp %h", chain_r, din); end
    n_cmp++; if (bus.chain_mode !== 1'b1) begin n_err++; $display("FAIL ext_mode got %b exp 1", bus.chain_mode); end
  endtask

  task automatic test_idcode();
    logic [31:0] din;
    logic [31:0] idv;
    idv = IDC;
    din = $urandom;
    reset_pulse();
    n_cmp++; if (bus.ir !== RST_INSTR) begin n_err++; $display("FAIL id_ir got %b exp %b", bus.ir, RST_INSTR); end
    step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      logic e;
`ifdef TAP_IDCODE_EN
      e = idv[i];
`else
      e = (i == 0) ? 1'b0 : din[i-1];
`endif
      step(i == 31, din[i]);
      n_cmp++;
      if (bus.tdo !== e) begin n_err++; $display("FAIL id_tdo bit%0d got %b exp %b", i, bus.tdo, e); end
    end
    step(1'b1, 1'b0); step(1'b0, 1'b0);
  endtask

  task automatic test_random();
    reset_pulse();
    for (int k = 0; k < 600; k++) begin
      logic [14:0] got, exp;
      pins_r = 8'($urandom_range(0, 255));
      step($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
      exp = {m_state, m_ir, m_tdo, m_en, m_mode,
             m_boundary() && (m_state == 4'h2), m_boundary() && (m_state == 4'h6),
             m_boundary() && (m_state == 4'h5), bus.tdi};
      got = {bus.tap_state, bus.ir, bus.tdo, bus.tdo_en, bus.chain_mode,
             bus.chain_shift, bus.chain_capture, bus.chain_update, bus.chain_si};
      n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL rand_cycle%0d got %h exp %h", k, got, exp); end
    end
  endtask

  initial begin
    nx0 = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
            4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
    nx1 = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
            4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};
    test_reset();
    test_tlr();
    test_ir_scan();
    test_bypass();
    test_extest();
    test_idcode();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
